pm_reg_bank: RTL and testbench

//  Parametrised path-metric register bank for the Viterbi decoder ACS loop.

---
 rtl/pm_reg_bank.sv | 92 +++++++++
 tb/tb_pm_reg_bank.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pm_reg_bank.sv
// Path-metric register bank for the Viterbi ACS loop.
// Loads all state metrics at once, renormalises modulo 2^(W-1), tracks argmin.
module pm_reg_bank #(
    parameter int N_STATES = 8,
    parameter int W        = 8,
    parameter int INIT_VAL = 64,
    parameter int CNT_W    = 8,
    localparam int SIDX_W  = $clog2(N_STATES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init,
    input  logic                  in_valid,
    input  logic [N_STATES*W-1:0] in_metrics,
    output logic [N_STATES*W-1:0] pm,
    output logic                  out_valid,
    output logic [SIDX_W-1:0]     best_state,
    output logic                  norm_flag,
    output logic [CNT_W-1:0]      norm_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic                  all_msb;
    logic [N_STATES*W-1:0] nxt_pm;
    logic [N_STATES*W-1:0] init_pm;
    logic [W-1:0]          min_val;
    logic [SIDX_W-1:0]     min_idx;

    always_comb begin
        all_msb = 1'b1;
        for (int k = 0; k < N_STATES; k++) begin
            all_msb = all_msb & in_metrics[k*W+W-1];
        end
    end

    // Renormalising only when every MSB is set preserves the ordering.
    always_comb begin
        nxt_pm = '0;
        for (int k = 0; k < N_STATES; k++) begin
            nxt_pm[k*W +: W] = {in_metrics[k*W+W-1] & ~all_msb,
                                in_metrics[k*W +: W-1]};
        end
    end

    always_comb begin
        init_pm = '0;
        for (int k = 1; k < N_STATES; k++) begin
            init_pm[k*W +: W] = W'(INIT_VAL);
        end
    end

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        min_val = in_metrics[0 +: W];
        min_idx = '0;
        for (int k = 1; k < N_STATES; k++) begin
            if (in_metrics[k*W +: W] < min_val) begin
                min_val = in_metrics[k*W +: W];
                min_idx = SIDX_W'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pm         <= '0;
            out_valid  <= 1'b0;
            best_state <= '0;
            norm_flag  <= 1'b0;
            norm_cnt   <= '0;
        end else if (init) begin
            pm         <= init_pm;
            out_valid  <= 1'b0;
            best_state <= '0;
            norm_flag  <= 1'b0;
            norm_cnt   <= '0;
        end else if (in_valid) begin
            pm         <= nxt_pm;
            out_valid  <= 1'b1;
            best_state <= min_idx;
            norm_flag  <= all_msb;
            if (all_msb && (norm_cnt != CNT_MAX)) begin
                norm_cnt <= norm_cnt + 1'b1;
            end
        end else begin
            out_valid <= 1'b0;
            norm_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pm_reg_bank.sv
// Scoreboard bench for pm_reg_bank (N_STATES=8, W=8, INIT_VAL=64, CNT_W=8).
// Loads push expectations; a negedge monitor pops them on out_valid.
module tb_pm_reg_bank;

    logic        clk;
    logic        rst_n;
    logic        init;
    logic        in_valid;
    logic [63:0] in_metrics;
    logic [63:0] pm;
    logic        out_valid;
    logic [2:0]  best_state;
    logic        norm_flag;
    logic [7:0]  norm_cnt;

    pm_reg_bank #(
        .N_STATES(8),
        .W(8),
        .INIT_VAL(64),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .init(init),
        .in_valid(in_valid),
        .in_metrics(in_metrics),
        .pm(pm),
        .out_valid(out_valid),
        .best_state(best_state),
        .norm_flag(norm_flag),
        .norm_cnt(norm_cnt)
    );

    typedef struct {
        logic [63:0] pm;
        int          best;
        bit          flag;
        int          cnt;
    } exp_t;

    exp_t        q[$];
    int          vectors = 0;
    int          fails   = 0;
    int          exp_cnt = 0;
    logic [63:0] last_pm;
    int          last_best;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pk(input int s0, input int s1,
                                       input int s2, input int s3,
                                       input int s4, input int s5,
                                       input int s6, input int s7);
        return {s7[7:0], s6[7:0], s5[7:0], s4[7:0],
                s3[7:0], s2[7:0], s1[7:0], s0[7:0]};
    endfunction

    // Caller sits at posedge+1; returns at posedge+1 after the capture edge.
    task automatic load(input logic [63:0] m, input int best,
                        input bit flag);
        exp_t        e;
        logic [63:0] mask;
        mask = {8{8'h7f}};
        if (flag && exp_cnt < 255) exp_cnt++;
        e.pm   = flag ? (m & mask) : m;
        e.best = best;
        e.flag = flag;
        e.cnt  = exp_cnt;
        q.push_back(e);
        last_pm   = e.pm;
        last_best = best;
        in_valid   = 1'b1;
        in_metrics = m;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pm", pm, e.pm);
                chk("best_state", 64'(best_state), 64'(e.best));
                chk("norm_flag", 64'(norm_flag), 64'(e.flag));
                chk("norm_cnt", 64'(norm_cnt), 64'(e.cnt));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        init       = 1'b0;
        in_valid   = 1'b0;
        in_metrics = '0;
        #1;
        chk("rst_pm", pm, 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_best", 64'(best_state), 64'd0);
        chk("rst_norm_cnt", 64'(norm_cnt), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        load(pk(10, 11, 12, 13, 14, 3, 16, 17), 5, 1'b0);
        load(pk(140, 148, 130, 164, 172, 180, 188, 196), 2, 1'b1);
        load(pk(140, 148, 130, 164, 172, 180, 127, 196), 6, 1'b0);
        load(pk(20, 20, 20, 7, 20, 20, 7, 20), 3, 1'b0);
        load(pk(255, 255, 255, 255, 255, 255, 255, 255), 0, 1'b1);
        load(pk(128, 255, 255, 255, 255, 255, 255, 255), 0, 1'b1);
        load(pk(0, 0, 0, 0, 0, 0, 0, 0), 0, 1'b0);
        load(pk(50, 50, 50, 50, 50, 50, 50, 1), 7, 1'b0);
        idle(2);

        in_valid   = 1'b1;
        in_metrics = pk(200, 200, 200, 200, 200, 200, 200, 150);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pm", pm, 64'd0);
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_best", 64'(best_state), 64'd0);
        chk("async_rst_norm_cnt", 64'(norm_cnt), 64'd0);
        chk("async_rst_norm_flag", 64'(norm_flag), 64'd0);
        @(posedge clk);
        #1;
        chk("rst_held_out_valid", 64'(out_valid), 64'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        exp_cnt  = 0;
        @(posedge clk);
        #1;

        load(pk(200, 200, 200, 200, 200, 200, 200, 150), 7, 1'b1);
        idle(2);
        init       = 1'b1;
        in_valid   = 1'b1;
        in_metrics = pk(200, 200, 200, 200, 200, 200, 200, 200);
        @(posedge clk);
        #1;
        init     = 1'b0;
        in_valid = 1'b0;
        exp_cnt  = 0;
        #1;
        chk("init_pm", pm, 64'h4040_4040_4040_4000);
        chk("init_out_valid", 64'(out_valid), 64'd0);
        chk("init_norm_cnt", 64'(norm_cnt), 64'd0);
        chk("init_best", 64'(best_state), 64'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 260; i++) begin
            int v[8];
            for (int k = 0; k < 8; k++) v[k] = 250;
            v[i % 8] = 128;
            load(pk(v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7]),
                 i % 8, 1'b1);
        end
        idle(2);
        chk("sat_norm_cnt", 64'(norm_cnt), 64'd255);

        load(pk(30, 31, 32, 33, 34, 35, 36, 9), 7, 1'b0);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #2;
            chk("hold_pm", pm, last_pm);
            chk("hold_best", 64'(best_state), 64'(last_best));
            chk("hold_out_valid", 64'(out_valid), 64'd0);
            chk("hold_norm_flag", 64'(norm_flag), 64'd0);
            chk("hold_norm_cnt", 64'(norm_cnt), 64'd255);
        end

        for (int i = 0; i < 20; i++) begin
            if (q.size() == 0) break;
            @(posedge clk);
        end
        chk("scoreboard_drain", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, fails);
        $finish;
    end

endmodule
